// File: rtl/qoi_enc_stream_if.sv
// Pixel-in / byte-out stream bundle for the QOI encoder.
// The slave modport is the encoder's view; master is the driving side.
interface qoi_enc_stream_if #(
  parameter int CHANNELS = 4
);
  logic                  px_valid;
  logic [8*CHANNELS-1:0] px_data;
  logic                  px_ready;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic                  out_ready;

  modport master (
    output px_valid, px_data, out_ready,
    input  px_ready, out_valid, out_data
  );

  modport slave (
    input  px_valid, px_data, out_ready,
    output px_ready, out_valid, out_data
  );
endinterface

// File: rtl/qoi_enc_stream.sv
// Streaming QOI image encoder: one pixel in, a short burst of op bytes out.
// Each pixel is classified as RUN, INDEX, DIFF, LUMA, RGBA or RGB, and the
// image is closed with the 8-byte end marker followed by a done pulse.
module qoi_enc_stream #(
  parameter int CHANNELS = 4,
  parameter int SIZE_W   = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  qoi_enc_stream_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic [SIZE_W-1:0] count
);
  typedef enum logic [2:0] {
    IDLE, FETCH, CLASSIFY, EMIT, RUN_FLUSH, END_MARK, FIN
  } state_t;

  localparam logic [31:0] PREV_INIT = 32'hFF00_0000;  // r=g=b=0, a=255

  state_t            state;
  logic [31:0]       px_table [64];
  logic [31:0]       prev;
  logic [31:0]       cur;
  logic [5:0]        run;
  logic [SIZE_W-1:0] img_size;
  logic [7:0]        enc_buf [8];
  logic [2:0]        enc_len;
  logic [2:0]        idx;
  logic              last;
  logic              pend;   // a pixel op is queued behind the run byte

  // Index position of a pixel: (3r+5g+7b+11a) mod 64
  function automatic logic [5:0] qoi_hash(input logic [31:0] p);
    logic [12:0] s;
    s = 13'd3  * {5'd0, p[7:0]}   + 13'd5  * {5'd0, p[15:8]} +
        13'd7  * {5'd0, p[23:16]} + 13'd11 * {5'd0, p[31:24]};
    return s[5:0];
  endfunction

  logic [31:0]       in_pix;
  logic [5:0]        h;
  logic signed [8:0] dr, dg, db, dr_dg, db_dg;
  logic              same, a_chg, use_diff, use_luma, is_last;
  logic [5:0]        run_inc;
  logic [7:0]        nb [8];
  logic [2:0]        nlen;

  // Incoming pixel normalised to RGBA; alpha is opaque for RGB images
  always_comb begin
    in_pix = {8'hFF, bus.px_data[23:0]};
    if (CHANNELS == 4) begin
      in_pix[31:24] = bus.px_data[8*CHANNELS-1 -: 8];
    end else begin
      in_pix[31:24] = 8'hFF;
    end
  end

  // Op selection for the pixel held in cur, relative to prev and the index
  always_comb begin
    h        = qoi_hash(cur);
    dr       = {1'b0, cur[7:0]}   - {1'b0, prev[7:0]};
    dg       = {1'b0, cur[15:8]}  - {1'b0, prev[15:8]};
    db       = {1'b0, cur[23:16]} - {1'b0, prev[23:16]};
    dr_dg    = dr - dg;
    db_dg    = db - dg;
    same     = (cur == prev);
    a_chg    = (cur[31:24] != prev[31:24]);
    is_last  = (count == img_size);
    run_inc  = run + 6'd1;
    use_diff = (dr >= -9'sd2) && (dr <= 9'sd1) &&
               (dg >= -9'sd2) && (dg <= 9'sd1) &&
               (db >= -9'sd2) && (db <= 9'sd1) && !a_chg;
    use_luma = (dg >= -9'sd32) && (dg <= 9'sd31) &&
               (dr_dg >= -9'sd8) && (dr_dg <= 9'sd7) &&
               (db_dg >= -9'sd8) && (db_dg <= 9'sd7);
    for (int i = 0; i < 8; i++) begin
      nb[i] = 8'h00;
    end
    nlen = 3'd1;
    if (px_table[h] == cur) begin
      nb[0] = {2'b00, h};
      nlen  = 3'd1;
    end else if (a_chg) begin
      nb[0] = 8'hFF;
      nb[1] = cur[7:0];
      nb[2] = cur[15:8];
      nb[3] = cur[23:16];
      nb[4] = cur[31:24];
      nlen  = 3'd5;
    end else if (use_diff) begin
      nb[0] = {2'b01, dr[1:0] + 2'd2, dg[1:0] + 2'd2, db[1:0] + 2'd2};
      nlen  = 3'd1;
    end else if (use_luma) begin
      nb[0] = {2'b10, dg[5:0] + 6'd32};
      nb[1] = {dr_dg[3:0] + 4'd8, db_dg[3:0] + 4'd8};
      nlen  = 3'd2;
    end else begin
      nb[0] = 8'hFE;
      nb[1] = cur[7:0];
      nb[2] = cur[15:8];
      nb[3] = cur[23:16];
      nlen  = 3'd4;
    end
  end

  // Encoder FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.px_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      count         <= '0;
      prev          <= PREV_INIT;
      cur           <= 32'h0000_0000;
      run           <= 6'd0;
      img_size      <= '0;
      enc_len       <= 3'd0;
      idx           <= 3'd0;
      last          <= 1'b0;
      pend          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            img_size <= size;
            count    <= '0;
            run      <= 6'd0;
            prev     <= PREV_INIT;
            busy     <= 1'b1;
            for (int i = 0; i < 64; i++) begin
              px_table[i] <= 32'h0000_0000;
            end
            if (size == '0) begin
              // Empty image: straight to the end marker
              bus.out_valid <= 1'b1;
              bus.out_data  <= 8'h00;
              idx           <= 3'd0;
              state         <= END_MARK;
            end else begin
              bus.px_ready <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.px_valid && bus.px_ready) begin
            cur          <= in_pix;
            count        <= count + SIZE_W'(1);
            bus.px_ready <= 1'b0;
            state        <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          last <= is_last;
          if (same) begin
            if ((run_inc == 6'd62) || is_last) begin
              // Byte holds run-1; run already counts the previous repeats
              bus.out_valid <= 1'b1;
              bus.out_data  <= {2'b11, run};
              run           <= 6'd0;
              pend          <= 1'b0;
              state         <= RUN_FLUSH;
            end else begin
              run          <= run_inc;
              bus.px_ready <= 1'b1;
              state        <= FETCH;
            end
          end else begin
            px_table[h] <= cur;
            prev        <= cur;
            enc_buf     <= nb;
            enc_len     <= nlen;
            run         <= 6'd0;
            bus.out_valid <= 1'b1;
            if (run != 6'd0) begin
              bus.out_data <= {2'b11, run - 6'd1};
              pend         <= 1'b1;
              state        <= RUN_FLUSH;
            end else begin
              bus.out_data <= nb[0];
              idx          <= 3'd1;
              state        <= EMIT;
            end
          end
        end
        RUN_FLUSH: begin
          if (bus.out_ready) begin
            if (pend) begin
              bus.out_data <= enc_buf[0];
              idx          <= 3'd1;
              state        <= EMIT;
            end else if (last) begin
              bus.out_data <= 8'h00;
              idx          <= 3'd0;
              state        <= END_MARK;
            end else begin
              bus.out_valid <= 1'b0;
              bus.px_ready  <= 1'b1;
              state         <= FETCH;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (idx == enc_len) begin
              if (last) begin
                bus.out_data <= 8'h00;
                idx          <= 3'd0;
                state        <= END_MARK;
              end else begin
                bus.out_valid <= 1'b0;
                bus.px_ready  <= 1'b1;
                state         <= FETCH;
              end
            end else begin
              bus.out_data <= enc_buf[idx];
              idx          <= idx + 3'd1;
            end
          end
        end
        END_MARK: begin
          if (bus.out_ready) begin
            if (idx == 3'd7) begin
              bus.out_valid <= 1'b0;
              bus.out_data  <= 8'h00;
              done          <= 1'b1;
              state         <= FIN;
            end else begin
              bus.out_data <= (idx == 3'd6) ? 8'h01 : 8'h00;
              idx          <= idx + 3'd1;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
